// File: rtl/sum_arb_pkg.sv
// Shared width helpers and constants for the shared-sum arbiter slice.
// Output sums are sized so a full-scale vector can never overflow.
package sum_arb_pkg;

    localparam int unsigned XFER_W = 16;

    function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
        return w + $clog2(n + 1) - 1;
    endfunction

    // Never narrower than one bit, so small configurations still get a valid index.
    function automatic int unsigned id_width(input int unsigned req);
        return (req < 2) ? 1 : $clog2(req);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
// The pointer register lives in the parent so it can advance only on a real transfer.
module rr_arbiter
    import sum_arb_pkg::*;
#(
    parameter int unsigned REQ  = 4,
    localparam int unsigned ID_W = id_width(REQ)
) (
    input  logic [REQ-1:0]  req,
    input  logic [ID_W-1:0] ptr,
    input  logic            enable,
    output logic [REQ-1:0]  grant,
    output logic [ID_W-1:0] grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < REQ; k++) begin
            idx = (32'(ptr) + k) % REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
        // grant_idx still steers the data mux; only the one-hot grant is gated.
        if (!enable) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/tree_adder.sv
// Combinational balanced adder tree: sums N unsigned lanes of WIDTH_IN bits.
// Every node is kept at the full output width, so no carry is ever lost.
module tree_adder
    import sum_arb_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned WIDTH_IN  = 1,
    localparam int unsigned WIDTH_OUT = sum_width(N, WIDTH_IN)
) (
    input  logic [N-1:0][WIDTH_IN-1:0] data,
    output logic [WIDTH_OUT-1:0]       sum
);

    localparam int unsigned LEVELS = $clog2(N);

    logic [WIDTH_OUT-1:0] node [LEVELS+1][N];

    always_comb begin
        for (int unsigned l = 0; l <= LEVELS; l++) begin
            for (int unsigned i = 0; i < N; i++) begin
                node[l][i] = '0;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            node[0][i] = WIDTH_OUT'(data[i]);
        end
        // Level l holds N >> l partial sums of adjacent pairs from level l-1.
        for (int unsigned l = 1; l <= LEVELS; l++) begin
            for (int unsigned i = 0; i < (N >> l); i++) begin
                node[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
            end
        end
        sum = node[LEVELS][0];
    end

endmodule

// File: rtl/shared_sum_arbiter.sv
// Time-multiplexes one tree_adder across REQ requesters with round-robin grants
// and a single registered, id-tagged result behind a valid/ready handshake.
module shared_sum_arbiter
    import sum_arb_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned WIDTH_IN  = 1,
    parameter int unsigned REQ       = 4,
    localparam int unsigned WIDTH_OUT = sum_width(N, WIDTH_IN),
    localparam int unsigned ID_W      = id_width(REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REQ-1:0]                     req_valid,
    output logic [REQ-1:0]                     req_ready,
    input  logic [REQ-1:0][N-1:0][WIDTH_IN-1:0] req_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH_OUT-1:0]               out_sum,
    output logic [ID_W-1:0]                    out_id,
    output logic [XFER_W-1:0]                  xfer_count
);

    if (N < 2 || !is_pow2(N)) begin : g_bad_n
        $error("shared_sum_arbiter: N must be a power of two and at least 2");
    end
    if (REQ < 2) begin : g_bad_req
        $error("shared_sum_arbiter: REQ must be at least 2");
    end

    logic [ID_W-1:0]               ptr;
    logic                          can_accept;
    logic                          arb_enable;
    logic [REQ-1:0]                grant;
    logic [ID_W-1:0]               grant_idx;
    logic [N-1:0][WIDTH_IN-1:0]    sel_data;
    logic [WIDTH_OUT-1:0]          tree_sum;
    logic                          xfer_in;
    logic                          xfer_out;

    assign can_accept = !out_valid || out_ready;
    // Holding ready low during reset keeps requesters from losing a vector.
    assign arb_enable = can_accept && !rst;
    assign req_ready  = grant;
    assign xfer_in    = |grant;
    assign xfer_out   = out_valid && out_ready;
    assign sel_data   = req_data[grant_idx];

    rr_arbiter #(
        .REQ (REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    tree_adder #(
        .N        (N),
        .WIDTH_IN (WIDTH_IN)
    ) u_tree_adder (
        .data (sel_data),
        .sum  (tree_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_id     <= '0;
            ptr        <= '0;
            xfer_count <= '0;
        end else begin
            if (xfer_in) begin
                out_valid <= 1'b1;
                out_sum   <= tree_sum;
                out_id    <= grant_idx;
                // Explicit wrap keeps ptr in range when REQ is not a power of two.
                ptr       <= (grant_idx == ID_W'(REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end else if (xfer_out) begin
                out_valid <= 1'b0;
            end
            if (xfer_out) begin
                xfer_count <= xfer_count + XFER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shared_sum_arbiter.sv
// Bench for shared_sum_arbiter: directed vector table, a rotation/countones
// reference model under random traffic, and a wide-lane instance for full-scale sums.
module tb_shared_sum_arbiter;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            req_valid;
    logic [3:0]            req_ready;
    logic [3:0][7:0][0:0]  req_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_sum;
    logic [1:0]            out_id;
    logic [15:0]           xfer_count;

    logic                  rst2;
    logic [3:0]            req_valid2;
    logic [3:0]            req_ready2;
    logic [3:0][3:0][3:0]  req_data2;
    logic                  out_valid2;
    logic                  out_ready2;
    logic [5:0]            out_sum2;
    logic [1:0]            out_id2;
    logic [15:0]           xfer_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_sum_arbiter #(.N(8), .WIDTH_IN(1), .REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_id     (out_id),
        .xfer_count (xfer_count)
    );

    shared_sum_arbiter #(.N(4), .WIDTH_IN(4), .REQ(4)) dut_wide (
        .clk        (clk),
        .rst        (rst2),
        .req_valid  (req_valid2),
        .req_ready  (req_ready2),
        .req_data   (req_data2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_sum    (out_sum2),
        .out_id     (out_id2),
        .xfer_count (xfer_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       oready;
        logic [3:0] exp_ready;
        logic       exp_ov;
        int         exp_sum;
        int         exp_id;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[19];

    // Reference model state
    logic        m_valid;
    int          m_sum;
    int          m_id;
    int          m_ptr;
    int          m_cnt;

    initial begin
        logic [3:0] e_ready;
        int         g;
        logic       r;
        logic [3:0] v;
        logic       orr;
        int         s;
        int         pick;

        // Fixed lane data: sums are 2, 4, 8, 4 for requesters 0..3.
        vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, 0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, 0};
        vecs[2]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 4, 1, 0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4, 1, 1};
        vecs[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2, 0, 1};
        vecs[5]  = '{1'b0, 4'b1100, 1'b0, 4'b0000, 1'b1, 2, 0, 1};
        vecs[6]  = '{1'b0, 4'b1100, 1'b0, 4'b0000, 1'b1, 2, 0, 1};
        vecs[7]  = '{1'b0, 4'b1100, 1'b0, 4'b0000, 1'b1, 2, 0, 1};
        vecs[8]  = '{1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8, 2, 2};
        vecs[9]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 4, 3, 3};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4, 3, 4};
        vecs[11] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 4, 1, 4};
        vecs[12] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 0, 0, 0};
        vecs[13] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2, 0, 0};
        vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4, 1, 1};
        vecs[15] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8, 2, 2};
        vecs[16] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4, 3, 3};
        vecs[17] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2, 0, 4};
        vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4, 1, 5};

        rst        = 1'b1;
        req_valid  = '0;
        out_ready  = 1'b1;
        req_data[0] = 8'h03;
        req_data[1] = 8'b1011_0001;
        req_data[2] = 8'hFF;
        req_data[3] = 8'h0F;
        rst2       = 1'b1;
        req_valid2 = '0;
        out_ready2 = 1'b1;
        req_data2  = '0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            req_valid = vecs[i].valid;
            out_ready = vecs[i].oready;
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_sum", i), 32'(out_sum), vecs[i].exp_sum);
            check($sformatf("vec%0d out_id", i), 32'(out_id), vecs[i].exp_id);
            check($sformatf("vec%0d xfer_count", i), 32'(xfer_count), vecs[i].exp_cnt);
        end

        // Random traffic against the reference model, starting from a reset.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        m_valid = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            r   = ($urandom_range(0, 24) == 0);
            v   = 4'($urandom_range(0, 15));
            orr = ($urandom_range(0, 3) != 0);
            rst       = r;
            req_valid = v;
            out_ready = orr;
            for (int i = 0; i < 4; i++) req_data[i] = 8'($urandom);
            e_ready = '0;
            g = -1;
            if (!r && !(m_valid && !orr)) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
                if (g >= 0) e_ready[g] = 1'b1;
            end
            #1;
            check($sformatf("rand%0d req_ready", c), 32'(req_ready), 32'(e_ready));
            if (r) begin
                m_valid = 1'b0; m_sum = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
            end else begin
                if (m_valid && orr) m_cnt = (m_cnt + 1) % 65536;
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_sum   = $countones(req_data[g]);
                    m_id    = g;
                    m_ptr   = (g + 1) % 4;
                end else if (m_valid && orr) begin
                    m_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("rand%0d out_valid", c), 32'(out_valid), 32'(m_valid));
            check($sformatf("rand%0d out_sum", c), 32'(out_sum), m_sum);
            check($sformatf("rand%0d out_id", c), 32'(out_id), m_id);
            check($sformatf("rand%0d xfer_count", c), 32'(xfer_count), m_cnt);
        end

        // Wide-lane instance: full-scale 4 x 15 must give 60 without overflow.
        @(negedge clk);
        rst2       = 1'b0;
        req_valid2 = 4'b0001;
        req_data2[0] = 16'hFFFF;
        #1;
        check("wide req_ready", 32'(req_ready2), 32'd1);
        @(posedge clk);
        #1;
        check("wide max out_valid", 32'(out_valid2), 32'd1);
        check("wide max out_sum", 32'(out_sum2), 32'd60);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pick = $urandom_range(0, 3);
            req_valid2 = '0;
            req_valid2[pick] = 1'b1;
            req_data2[pick] = 16'($urandom);
            s = 0;
            for (int l = 0; l < 4; l++) s += int'(req_data2[pick][l]);
            @(posedge clk);
            #1;
            check($sformatf("wide%0d out_sum", c), 32'(out_sum2), s);
            check($sformatf("wide%0d out_id", c), 32'(out_id2), pick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
